// File: rtl/ctrl_issue_unit.sv
// rtl/ctrl_issue_unit.sv - ID-to-EX control decode and issue with multi-cycle FPU wait
module ctrl_issue_unit #(
  parameter int unsigned MC_LAT    = 4,
  parameter bit          ENABLE_MC = 1'b1,
  parameter logic [6:0]  MC_F7_A   = 7'b0001100,
  parameter logic [6:0]  MC_F7_B   = 7'b0101100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [6:0]  opcode_id,
  input  logic [6:0]  funct7_id,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        in_ready,
  output logic        out_valid,
  output logic [10:0] ctrl_ex,
  output logic        illegal_ex,
  output logic        mc_busy
);

  typedef enum logic {IDLE, MC_WAIT} state_t;

  localparam logic [6:0] OP_FPU  = 7'b1010011;
  localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [10:0] mc_word_q, mc_word_d;
  logic        out_valid_q, out_valid_d;
  logic [10:0] ctrl_q, ctrl_d;
  logic        illegal_q, illegal_d;

  logic [10:0] dec_word;
  logic        dec_illegal;
  logic        is_nop, is_mc, accept, transfer;

  always_comb begin
    dec_word    = 11'b0;
    dec_illegal = 1'b0;
    case (opcode_id)
      7'b0010011: dec_word = 11'b10010000000;
      7'b0110011: dec_word = 11'b00010001000;
      7'b0000011: dec_word = 11'b11011000000;
      7'b0100011: dec_word = 11'b10000100000;
      7'b1100011: dec_word = 11'b00000010100;
      7'b0000111: dec_word = 11'b11101000000;
      7'b0100111: dec_word = 11'b10000100001;
      OP_FPU: begin
        case (funct7_id)
          7'b0011000: dec_word = 11'b00010001110;
          7'b0011100: dec_word = 11'b00100001100;
          default:    dec_word = 11'b00100001111;
        endcase
      end
      7'b0000000: dec_word = 11'b0;
      default:    dec_illegal = 1'b1;
    endcase
  end

  assign is_nop   = (opcode_id == 7'b0000000);
  assign is_mc    = ENABLE_MC && (opcode_id == OP_FPU) &&
                    ((funct7_id == MC_F7_A) || (funct7_id == MC_F7_B));
  assign in_ready = !rst && !flush && (state_q == IDLE) && (!out_valid_q || ex_ready);
  assign accept   = in_valid && in_ready;
  assign transfer = out_valid_q && ex_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mc_word_d   = mc_word_q;
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    illegal_d   = illegal_q;
    if (flush) begin
      state_d     = IDLE;
      cnt_d       = 4'd0;
      out_valid_d = 1'b0;
      ctrl_d      = 11'b0;
      illegal_d   = 1'b0;
    end else begin
      // A drained output returns to zero so ctrl_ex never shows a stale word.
      if (transfer) begin
        out_valid_d = 1'b0;
        ctrl_d      = 11'b0;
        illegal_d   = 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept && !is_nop) begin
            if (is_mc) begin
              state_d   = MC_WAIT;
              cnt_d     = MC_LOAD;
              mc_word_d = dec_word;
            end else begin
              out_valid_d = 1'b1;
              ctrl_d      = dec_word;
              illegal_d   = dec_illegal;
            end
          end
        end
        MC_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else if (!out_valid_q || ex_ready) begin
            out_valid_d = 1'b1;
            ctrl_d      = mc_word_q;
            illegal_d   = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      mc_word_q   <= 11'b0;
      out_valid_q <= 1'b0;
      ctrl_q      <= 11'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mc_word_q   <= mc_word_d;
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign ctrl_ex    = ctrl_q;
  assign illegal_ex = illegal_q;
  assign mc_busy    = (state_q == MC_WAIT);

endmodule
